fetch_unit: RTL
===============

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h00000000, PC value loaded by reset.
REQ-002 Parameter IMEM_TIMEOUT, default 15, max wait cycles for imem_ready before ErrF asserts.
REQ-003 CLK  in  1  single clock; all state updates on posedge.
REQ-004 RST  in  1  reset, asynchronous, active-low.
REQ-005 StallF  in  1  hazard-unit hold; PC and outputs frozen while high.
REQ-006 PCSrcD  in  1  taken branch resolved in decode.
REQ-007 PCBranchD  in  32  branch target.
REQ-008 JumpD  in  1  jump in decode.
REQ-009 PCJumpD  in  32  jump target.
REQ-010 imem_req  out  1  instruction memory request.
REQ-011 imem_addr  out  32  request address, word aligned.
REQ-012 imem_ready  in  1  memory returns imem_rdata this cycle.
REQ-013 imem_rdata  in  32  fetched instruction word.
REQ-014 InstrF  out  32  instruction to the IF/ID register.
REQ-015 PCPlus4F  out  32  PCF+4, to the IF/ID register.
REQ-016 PCF  out  32  address of InstrF.
REQ-017 ValidF  out  1  InstrF/PCPlus4F hold a valid fetched instruction.
REQ-018 MemWaitF  out  1  fetch waiting on memory; hazard unit stalls decode.
REQ-019 ErrF  out  1  sticky timeout error.

Function
REQ-020 FSM states: IDLE, REQ, HOLD, ERR; IDLE entered only from reset.
REQ-021 IDLE -> REQ on first clock after reset release, imem_addr=PC.
REQ-022 REQ: imem_req=1, MemWaitF=1; on imem_ready capture imem_rdata into InstrF, set PCF=PC, ValidF=1.
REQ-023 On capture, next PC = PC+4 (modulo 2^32, wraps FFFFFFFC -> 00000000); if StallF=0 stay in REQ for next address, else go HOLD.
REQ-024 HOLD: imem_req=0, outputs unchanged; leave to REQ when StallF=0.
REQ-025 Redirect priority: JumpD over PCSrcD over sequential; redirect sets PC to target with low two bits forced to 0.
REQ-026 Redirect in REQ with imem_ready same cycle: returned word discarded, ValidF=0, next request uses target.
REQ-027 Redirect in REQ without imem_ready: kill flag set; the next returned word is discarded, then a new request issues to the target; imem_addr stable while request outstanding.
REQ-028 Redirect ignored while StallF=1 except in REQ with request outstanding (handled per REQ-027), target latched for use on release.
REQ-029 ValidF=0 whenever no captured instruction is current (after redirect, during first fetch).
REQ-030 Wait counter counts REQ cycles without imem_ready; reaching IMEM_TIMEOUT -> ERR: imem_req=0, ErrF=1, ValidF=0; exit only by reset.
REQ-031 PCPlus4F always equals PCF+4 combinationally from registered PCF.

Reset
REQ-032 RST low asynchronously: state IDLE, PC=RESET_PC, PCF=RESET_PC, PCPlus4F=RESET_PC+4, InstrF=0, ValidF=0, imem_req=0, MemWaitF=0, ErrF=0, counter=0, kill flag=0.
REQ-033 Reset mid-request abandons it; a late imem_ready after reset release while not requesting is ignored.

Structure
REQ-034 Shared pipeline package holds FSM state encoding, RESET_PC default, and the NOP/zero instruction constant.
REQ-035 One sub-module pc_next_sel: combinational next-PC mux (sequential/branch/jump, alignment); remainder in fetch_unit.

Verification
REQ-036 Reset, imem_ready every cycle -> PCF 0,4,8,C on successive cycles, ValidF=1 from second cycle.
REQ-037 imem_ready delayed 3 cycles -> MemWaitF=1 for 3 cycles, InstrF updates once, imem_addr stable.
REQ-038 PCSrcD=1, PCBranchD=32'h00000103 while request outstanding -> returned word dropped, next imem_addr=32'h00000100.
REQ-039 JumpD and PCSrcD same cycle, targets 0x200/0x300 -> imem_addr=0x200.
REQ-040 StallF high 4 cycles after capture -> InstrF, PCF, PCPlus4F unchanged, imem_req=0; resumes at PC+4.
REQ-041 imem_ready never asserts -> ErrF=1 after 15 cycles, stays until RST low.

Source files
------------

// File: rtl/fetch_unit_pkg.sv
// Shared fetch-stage definitions: FSM state encoding, reset PC default,
// the NOP/zero instruction word and a word-alignment helper.
package fetch_unit_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_HOLD = 2'd2,
    ST_ERR  = 2'd3
  } fetch_state_e;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_unit_pc_next_sel.sv
// Next-PC selection: jump beats branch beats sequential, and every
// selected address is forced onto a word boundary.
module pc_next_sel
  import fetch_unit_pkg::*;
(
  input  logic [31:0] pc_i,
  input  logic        jump_i,
  input  logic [31:0] jump_tgt_i,
  input  logic        branch_i,
  input  logic [31:0] branch_tgt_i,
  output logic        redirect_o,
  output logic [31:0] pc_next_o
);

  always_comb begin
    redirect_o = jump_i | branch_i;
    if (jump_i) begin
      pc_next_o = word_align(jump_tgt_i);
    end else if (branch_i) begin
      pc_next_o = word_align(branch_tgt_i);
    end else begin
      pc_next_o = word_align(pc_i + 32'd4);
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: issues word requests to instruction memory,
// captures returned words, handles stalls, redirects and memory timeouts.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC     = RESET_PC_DEFAULT,
  parameter int          IMEM_TIMEOUT = 15
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        StallF,
  input  logic        PCSrcD,
  input  logic [31:0] PCBranchD,
  input  logic        JumpD,
  input  logic [31:0] PCJumpD,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] InstrF,
  output logic [31:0] PCPlus4F,
  output logic [31:0] PCF,
  output logic        ValidF,
  output logic        MemWaitF,
  output logic        ErrF
);

  localparam int CNT_W = (IMEM_TIMEOUT < 2) ? 1 : $clog2(IMEM_TIMEOUT + 1);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  pcf_q, pcf_d;
  logic [31:0]  instr_q, instr_d;
  logic         valid_q, valid_d;
  logic         err_q, err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic         kill_q, kill_d;
  logic         pend_q, pend_d;
  logic [31:0]  tgt_q, tgt_d;

  logic         redirect;
  logic [31:0]  pc_next;

  pc_next_sel u_pc_next_sel (
    .pc_i         (pc_q),
    .jump_i       (JumpD),
    .jump_tgt_i   (PCJumpD),
    .branch_i     (PCSrcD),
    .branch_tgt_i (PCBranchD),
    .redirect_o   (redirect),
    .pc_next_o    (pc_next)
  );

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    pcf_d    = pcf_q;
    instr_d  = instr_q;
    valid_d  = valid_q;
    err_d    = err_q;
    cnt_d    = cnt_q;
    kill_d   = kill_q;
    pend_d   = pend_q;
    tgt_d    = tgt_q;
    imem_req = 1'b0;
    MemWaitF = 1'b0;
    case (state_q)
      ST_IDLE: state_d = ST_REQ;
      ST_REQ: begin
        imem_req = 1'b1;
        MemWaitF = 1'b1;
        if (imem_ready) begin
          cnt_d = '0;
          if (kill_q) begin
            // Word belongs to the abandoned path; a fresher redirect wins.
            kill_d = 1'b0;
            pc_d   = redirect ? pc_next : tgt_q;
          end else if (redirect) begin
            valid_d = 1'b0;
            pc_d    = pc_next;
          end else begin
            MemWaitF = 1'b0;
            instr_d  = imem_rdata;
            pcf_d    = pc_q;
            valid_d  = 1'b1;
            pc_d     = pc_next;
            if (StallF) state_d = ST_HOLD;
          end
        end else if (int'(cnt_q) + 1 >= IMEM_TIMEOUT) begin
          state_d = ST_ERR;
          valid_d = 1'b0;
          err_d   = 1'b1;
          kill_d  = 1'b0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          // Address must stay put while the request is outstanding.
          if (redirect) begin
            kill_d  = 1'b1;
            tgt_d   = pc_next;
            valid_d = 1'b0;
          end
        end
      end
      ST_HOLD: begin
        if (redirect) begin
          pend_d = 1'b1;
          tgt_d  = pc_next;
        end
        if (!StallF) begin
          state_d = ST_REQ;
          pend_d  = 1'b0;
          if (redirect) begin
            pc_d    = pc_next;
            valid_d = 1'b0;
          end else if (pend_q) begin
            pc_d    = tgt_q;
            valid_d = 1'b0;
          end
        end
      end
      ST_ERR: begin
        valid_d = 1'b0;
        err_d   = 1'b1;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= ST_IDLE;
      pc_q    <= RESET_PC;
      pcf_q   <= RESET_PC;
      instr_q <= NOP_INSTR;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
      kill_q  <= 1'b0;
      pend_q  <= 1'b0;
      tgt_q   <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      pcf_q   <= pcf_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
      kill_q  <= kill_d;
      pend_q  <= pend_d;
      tgt_q   <= tgt_d;
    end
  end

  assign imem_addr = pc_q;
  assign InstrF    = instr_q;
  assign PCF       = pcf_q;
  assign PCPlus4F  = pcf_q + 32'd4;
  assign ValidF    = valid_q;
  assign ErrF      = err_q;

endmodule
